// File: rtl/cache_refill_arbiter_pkg.sv
// cache_refill_arbiter_pkg: shared states, requester ids, tag field offsets and default widths
package cache_refill_arbiter_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int LINE_W_DEF = 128;
  localparam int TAG_W_DEF = 9;
  localparam int MAX_WAIT_DEF = 15;
  localparam int VALID_BIT = 0;
  localparam int LINE_LSB = 2;
  localparam int AGE_LSB = 5;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  typedef enum logic {REQ_DC, REQ_IC} req_id_t;
endpackage

// File: rtl/refill_rr_arb.sv
// refill_rr_arb: 2-way round-robin arbiter (req_dc/req_ic in, one-hot gnt {ic,dc} out, last grant updated on accept)
module refill_rr_arb
  import cache_refill_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_dc,
  input  logic       req_ic,
  input  logic       accept,
  output logic [1:0] gnt
);
  req_id_t last_grant;
  always_comb gnt = (req_dc && req_ic) ? ((last_grant == REQ_IC) ? 2'b01 : 2'b10) : {req_ic, req_dc};
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= REQ_IC;
    else if (accept && |gnt) last_grant <= gnt[0] ? REQ_DC : REQ_IC;
endmodule

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter: arbitrates dc/ic misses onto one memory line port, sequences REQ/FILL, returns line+tag via fill strobes, drives stall/busy/timeout_err
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_miss,
  input  logic [ADDR_W-1:0] dc_miss_addr,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              dc_fill,
  output logic              ic_fill,
  output logic [LINE_W-1:0] fill_line,
  output logic [TAG_W-1:0]  fill_tag,
  output logic              stall,
  output logic              busy,
  output logic              timeout_err
);
  state_t state, state_n;
  req_id_t id, id_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] gnt;
  logic mem_req_n, dc_fill_n, ic_fill_n, terr_n;
  logic [ADDR_W-3:0] addr_n;
  logic [LINE_W-1:0] line_n;
  logic [TAG_W-1:0] tag_n, new_tag;
  logic unused_offsets;
  assign unused_offsets = ^{dc_miss_addr[1:0], ic_miss_addr[1:0]};
  assign busy = state != IDLE;
  assign stall = dc_miss | busy;
  refill_rr_arb u_arb (
    .clk(clk),
    .rst(rst),
    .req_dc(dc_miss),
    .req_ic(ic_miss),
    .accept(state == IDLE),
    .gnt(gnt)
  );
  always_comb begin
    new_tag = '0;
    new_tag[VALID_BIT] = 1'b1;
    new_tag[AGE_LSB +: 3] = 3'b000;
    new_tag[LINE_LSB +: 3] = mem_addr[2:0];
    state_n = state;
    id_n = id;
    cnt_n = cnt;
    mem_req_n = mem_req;
    addr_n = mem_addr;
    line_n = fill_line;
    tag_n = fill_tag;
    dc_fill_n = 1'b0;
    ic_fill_n = 1'b0;
    terr_n = 1'b0;
    case (state)
      IDLE: if (|gnt) begin
        state_n = REQ;
        mem_req_n = 1'b1;
        cnt_n = '0;
        id_n = gnt[0] ? REQ_DC : REQ_IC;
        addr_n = gnt[0] ? dc_miss_addr[ADDR_W-1:2] : ic_miss_addr[ADDR_W-1:2];
      end
      REQ: if (mem_ack) begin
        state_n = FILL;
        mem_req_n = 1'b0;
        cnt_n = '0;
        line_n = mem_rdata;
        tag_n = new_tag;
        dc_fill_n = id == REQ_DC;
        ic_fill_n = id == REQ_IC;
      end else if (cnt == 4'(MAX_WAIT - 1)) begin
        state_n = IDLE;
        mem_req_n = 1'b0;
        cnt_n = '0;
        terr_n = 1'b1;
      end else cnt_n = cnt + 4'd1;
      FILL: begin
        state_n = IDLE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      id <= REQ_DC;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      fill_line <= '0;
      fill_tag <= '0;
      dc_fill <= 1'b0;
      ic_fill <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      id <= id_n;
      cnt <= cnt_n;
      mem_req <= mem_req_n;
      mem_addr <= addr_n;
      fill_line <= line_n;
      fill_tag <= tag_n;
      dc_fill <= dc_fill_n;
      ic_fill <= ic_fill_n;
      timeout_err <= terr_n;
    end
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb_cache_refill_arbiter: directed stimulus with a scoreboard queue checked by a fill/timeout monitor
module tb_cache_refill_arbiter;
  logic clk = 0, rst = 1;
  logic dc_miss = 0, ic_miss = 0, mem_ack = 0;
  logic [4:0] dc_miss_addr = '0, ic_miss_addr = '0;
  logic [127:0] mem_rdata = '0;
  logic mem_req, dc_fill, ic_fill, stall, busy, timeout_err;
  logic [2:0] mem_addr;
  logic [127:0] fill_line;
  logic [8:0] fill_tag;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [2:0]   kind;
    logic [127:0] line;
    logic [8:0]   tag;
  } ev_t;
  ev_t q[$];
  localparam logic [2:0] K_DC = 3'b001, K_IC = 3'b010, K_TO = 3'b100;

  cache_refill_arbiter dut (
    .clk(clk), .rst(rst),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dc_fill(dc_fill), .ic_fill(ic_fill),
    .fill_line(fill_line), .fill_tag(fill_tag),
    .stall(stall), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [127:0] l, input logic [8:0] t);
    ev_t e;
    e.kind = k;
    e.line = l;
    e.tag = t;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (dc_fill || ic_fill || timeout_err)) begin
      if (q.size() == 0) chk("unexpected_event", {125'd0, timeout_err, ic_fill, dc_fill}, '0);
      else begin
        e = q.pop_front();
        chk("event_kind", {125'd0, timeout_err, ic_fill, dc_fill}, {125'd0, e.kind});
        if (e.kind != K_TO) begin
          chk("fill_line", fill_line, e.line);
          chk("fill_tag", {119'd0, fill_tag}, {119'd0, e.tag});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1;
    dc_miss = 0;
    ic_miss = 0;
    mem_ack = 0;
    cyc();
    cyc();
    rst = 0;
  endtask

  initial begin
    cyc();
    @(negedge clk);
    chk("rst_outputs", {122'd0, mem_req, dc_fill, ic_fill, timeout_err, busy, stall}, '0);
    chk("rst_addr_tag", {116'd0, mem_addr, fill_tag}, '0);
    chk("rst_line", fill_line, '0);
    cyc();
    rst = 0;
    // single data miss, ack on fourth REQ cycle
    dc_miss = 1;
    dc_miss_addr = 5'b10110;
    @(negedge clk);
    chk("t1_idle_stall", {126'd0, stall, mem_req}, 128'd2);
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_req_wait", {123'd0, mem_req, mem_addr, stall}, {123'd0, 1'b1, 3'b101, 1'b1});
      cyc();
    end
    mem_ack = 1;
    mem_rdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    push(K_DC, mem_rdata, 9'h015);
    @(negedge clk);
    chk("t1_req_ack", {124'd0, mem_req, mem_addr}, {124'd0, 1'b1, 3'b101});
    cyc();
    mem_ack = 0;
    dc_miss = 0;
    @(negedge clk);
    chk("t1_fill_state", {125'd0, busy, stall, mem_req}, 128'd6);
    cyc();
    @(negedge clk);
    chk("t1_idle_after", {125'd0, busy, stall, mem_req}, '0);
    // tie after reset: dc, then ic, then dc again
    do_reset();
    dc_miss = 1;
    ic_miss = 1;
    dc_miss_addr = 5'b00100;
    ic_miss_addr = 5'b01100;
    cyc();
    @(negedge clk);
    chk("t2_first_dc", {124'd0, mem_req, mem_addr}, {124'd0, 1'b1, 3'b001});
    mem_ack = 1;
    mem_rdata = 128'h1111;
    push(K_DC, 128'h1111, 9'h005);
    cyc();
    mem_ack = 0;
    dc_miss = 0;
    cyc();
    cyc();
    @(negedge clk);
    chk("t2_then_ic", {124'd0, mem_req, mem_addr}, {124'd0, 1'b1, 3'b011});
    mem_ack = 1;
    mem_rdata = 128'h2222;
    push(K_IC, 128'h2222, 9'h00D);
    cyc();
    mem_ack = 0;
    dc_miss = 1;
    cyc();
    cyc();
    @(negedge clk);
    chk("t2_tie_dc_again", {124'd0, mem_req, mem_addr}, {124'd0, 1'b1, 3'b001});
    mem_ack = 1;
    mem_rdata = 128'h3333;
    push(K_DC, 128'h3333, 9'h005);
    cyc();
    mem_ack = 0;
    dc_miss = 0;
    ic_miss = 0;
    cyc();
    // timeout on instruction miss, then retry
    ic_miss = 1;
    ic_miss_addr = 5'b01000;
    push(K_TO, '0, '0);
    cyc();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t3_req_hold", {125'd0, mem_req, timeout_err, busy}, 128'd5);
      cyc();
    end
    @(negedge clk);
    chk("t3_dropped", {126'd0, mem_req, busy}, '0);
    cyc();
    @(negedge clk);
    chk("t3_retry", {124'd0, mem_req, mem_addr}, {124'd0, 1'b1, 3'b010});
    mem_ack = 1;
    mem_rdata = 128'h4444_0000_5555;
    push(K_IC, 128'h4444_0000_5555, 9'h009);
    cyc();
    mem_ack = 0;
    ic_miss = 0;
    cyc();
    // ack on the 15th REQ cycle wins over timeout
    dc_miss = 1;
    dc_miss_addr = 5'b11100;
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    mem_ack = 1;
    mem_rdata = 128'h7777_8888;
    push(K_DC, 128'h7777_8888, 9'h01D);
    @(negedge clk);
    chk("t5_req15", {126'd0, mem_req, timeout_err}, 128'd2);
    cyc();
    mem_ack = 0;
    dc_miss = 0;
    @(negedge clk);
    chk("t5_no_timeout_fill", {126'd0, timeout_err, busy}, 128'd1);
    cyc();
    @(negedge clk);
    chk("t5_no_timeout_idle", {127'd0, timeout_err}, '0);
    // async reset mid-REQ with coincident ack
    dc_miss = 1;
    dc_miss_addr = 5'b10010;
    cyc();
    cyc();
    mem_ack = 1;
    mem_rdata = 128'h9999;
    rst = 1;
    #1;
    chk("t4_rst_ctrl", {122'd0, mem_req, dc_fill, ic_fill, timeout_err, busy, 1'b0}, '0);
    chk("t4_rst_data", fill_line | {116'd0, mem_addr, fill_tag}, '0);
    dc_miss = 0;
    mem_ack = 0;
    cyc();
    rst = 0;
    for (int i = 0; i < 4; i++) cyc();
    @(negedge clk);
    chk("t4_after_rst", {124'd0, mem_req, dc_fill, ic_fill, busy}, '0);
    chk("scoreboard_empty", 128'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
Shares the single backing-memory line port between instruction-cache and data-cache miss requests. On a miss it sequences one 128-bit line refill and returns the line plus a formatted 9-bit tag to the requesting cache. The data cache takes it on its WDCache/WDCacheline/WDCachetag inputs; the instruction cache has an equivalent port. It sits between the fetch and memory stages and the memory model. While a refill is outstanding it holds the pipeline stall.

Parameters:
ADDR_W, 5, miss address width; [ADDR_W-1:2] is the line address, [1:0] the word offset
LINE_W, 128, cache line width
TAG_W, 9, cache tag width; [0] valid, [4:2] line address, [7:5] LRU age, [1] and [8] reserved
MAX_WAIT, 15, REQ cycles without mem_ack before abort (4-bit counter)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
dc_miss  in  1  data-cache miss, level
dc_miss_addr  in  ADDR_W  data miss address
ic_miss  in  1  instruction-cache miss, level
ic_miss_addr  in  ADDR_W  instruction miss address
mem_req  out  1  line read request to memory
mem_addr  out  ADDR_W-2  line address of the request
mem_ack  in  1  memory returns line this cycle
mem_rdata  in  LINE_W  returned line
dc_fill  out  1  one-cycle write strobe to data cache
ic_fill  out  1  one-cycle write strobe to instruction cache
fill_line  out  LINE_W  line to write
fill_tag  out  TAG_W  tag to write
stall  out  1  pipeline Nop request to upstream stages
busy  out  1  FSM not IDLE
timeout_err  out  1  one-cycle pulse on refill abort

Behaviour:
- Reset, asynchronous: state=IDLE. mem_req, mem_addr, dc_fill, ic_fill, fill_line, fill_tag, timeout_err, and the wait counter are 0. last_grant=IC, so DC wins the first tie. A reset in the middle of a refill discards it and never emits a fill strobe.
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - If dc_miss or ic_miss is high, latch the winner's address and id and go to REQ.
  - Tie rule: when both are high, grant the side that is not last_grant; last_grant updates on every grant.
  - Single requester: grant it.
  - mem_ack in IDLE is ignored.
- REQ:
  - mem_req=1 (registered) with mem_addr = latched address [ADDR_W-1:2].
  - On mem_ack: capture mem_rdata into fill_line, form fill_tag, drop mem_req, go to FILL.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT with no ack: drop mem_req, pulse timeout_err for one cycle, clear the counter, go to IDLE. The miss is still pending, so the next IDLE cycle re-arbitrates.
- FILL: exactly one cycle. dc_fill or ic_fill=1 according to the latched id; fill_line and fill_tag are valid. Next state is IDLE. The counter clears.
- fill_tag = {1'b0, 3'b000, line_addr[2:0], 1'b0, 1'b1}: valid set, age 0.
- fill_line and fill_tag hold their values after FILL; they are qualified only by the strobes.
- Latency: miss high in IDLE at cycle 0 → mem_req high at cycle 1. mem_ack in cycle k → fill strobe in cycle k+1 → IDLE at k+2. Minimum 3 cycles from miss to IDLE.
- The cache writes on the edge that ends FILL, so its combinational miss is already low in the following IDLE cycle. No drain state is needed.
- A miss whose address changes during REQ is not tracked; the latched address is served.
- Miss lines that fall during REQ do not cancel the refill; the fill is still delivered.
- stall = dc_miss | busy (combinational). busy = (state != IDLE).
- mem_ack arriving in the same cycle as the wait counter reaches MAX_WAIT: the ack wins; no timeout.

Decomposition:
- Shared package: state encoding (IDLE/REQ/FILL), requester id enum (REQ_DC, REQ_IC), tag field offsets (VALID_BIT=0, LINE_LSB=2, AGE_LSB=5), and the default widths.
- Natural sub-module: refill_rr_arb, a 2-way round-robin arbiter (two request inputs, grant one-hot, last_grant register, update on accept).

Test Plan:
- dc_miss=1, dc_miss_addr=5'b10110, memory acks 4 cycles after mem_req → mem_addr=3'b101 from cycle 1 to the ack; dc_fill pulses once the cycle after the ack; fill_tag=9'h015; fill_line equals mem_rdata; ic_fill stays 0.
- dc_miss and ic_miss both high after reset (addrs 5'b00100, 5'b01100) → DC served first (mem_addr=3'b001), then IC (3'b011); with both held again, the next tie goes to DC.
- ic_miss held, mem_ack never asserted → mem_req drops after 15 REQ cycles, timeout_err pulses once, and a new REQ for the same address starts 2 cycles later.
- rst asserted mid-REQ with mem_ack pulsing in the same cycle → all outputs 0 immediately; no dc_fill or ic_fill after reset release.
- mem_ack coinciding with the 15th REQ cycle → fill delivered, timeout_err stays 0.
- dc_miss high only → stall=1 in the IDLE cycle and throughout REQ and FILL; stall=0 the first IDLE cycle after dc_miss falls.
